// File: rtl/saradc_pkg.sv
// Shared types and register map for the SAR ADC sequencer.
// Register offsets are word indices taken from wbs_adr_i[3:2].
package saradc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_CONV = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_CONT    = 1;
    localparam int CTRL_CAL     = 2;
    localparam int CTRL_IE_DATA = 4;
    localparam int CTRL_IE_ERR  = 5;

    localparam int STS_BUSY      = 0;
    localparam int STS_COUNT_LSB = 1;
    localparam int STS_OVF       = 4;
    localparam int STS_TOUT      = 5;
    localparam int STS_CAL_DONE  = 6;

    localparam logic [31:0] DATA_EMPTY = 32'h8000_0000;

endpackage

// File: rtl/saradc_fifo.sv
// Synchronous FIFO; registered count/flags, dout is the head entry (combinational read).
// A push while full is dropped unless a pop happens in the same cycle.
module saradc_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/saradc_seq.sv
// SAR ADC sequencer: drives adc_en/adc_cal, captures results on valid rising edge into a FIFO.
// Wishbone ack one cycle after request, never back-to-back; full FIFO drops samples and flags OVF.
module saradc_seq
    import saradc_pkg::*;
#(
    parameter int RES_W      = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic [31:0]      wbs_dat_o,
    output logic             wbs_ack_o,
    output logic             adc_en,
    output logic             adc_cal,
    input  logic             adc_valid,
    input  logic [RES_W-1:0] adc_result,
    output logic             irq
);
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam int FAW = $clog2(FIFO_DEPTH);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ack_q, ack_d;
    logic            valid_q, valid_d;
    logic            adc_en_q, adc_en_d;
    logic            adc_cal_q, adc_cal_d;
    logic            cont_q, cont_d;
    logic            ie_data_q, ie_data_d;
    logic            ie_err_q, ie_err_d;
    logic            ovf_q, ovf_d;
    logic            tout_q, tout_d;
    logic            cal_done_q, cal_done_d;

    logic            acc, wr, rd, ctrl_wr, status_wr, start_wr, cal_wr;
    logic            valid_edge, tout_hit, cal_done_set;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]      reg_sel;
    logic [RES_W-1:0] fifo_dout;
    logic [FAW:0]    fifo_count;
    logic [31:0]     rdata;
    logic            unused_bits;

    // Side effects land in the ack cycle while the master still holds the request.
    assign acc       = ack_q & wbs_cyc_i & wbs_stb_i;
    assign reg_sel   = wbs_adr_i[3:2];
    assign wr        = acc & wbs_we_i & wbs_sel_i[0];
    assign rd        = acc & ~wbs_we_i;
    assign ctrl_wr   = wr & (reg_sel == REG_CTRL);
    assign status_wr = wr & (reg_sel == REG_STATUS);
    assign start_wr  = ctrl_wr & wbs_dat_i[CTRL_START];
    assign cal_wr    = ctrl_wr & wbs_dat_i[CTRL_CAL];

    assign valid_edge = adc_valid & ~valid_q;
    assign tout_hit   = ((state_q == ST_CAL) || (state_q == ST_CONV)) && !valid_edge
                        && (cnt_q == CW'(TIMEOUT));
    assign fifo_push  = (state_q == ST_CONV) & valid_edge;
    assign fifo_pop   = rd & (reg_sel == REG_DATA);

    saradc_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (adc_result),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        ack_d        = wbs_cyc_i & wbs_stb_i & ~ack_q;
        valid_d      = adc_valid;
        cont_d       = ctrl_wr ? wbs_dat_i[CTRL_CONT] : cont_q;
        if (tout_hit) cont_d = 1'b0;
        ie_data_d    = ctrl_wr ? wbs_dat_i[CTRL_IE_DATA] : ie_data_q;
        ie_err_d     = ctrl_wr ? wbs_dat_i[CTRL_IE_ERR]  : ie_err_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        cal_done_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cal_wr) begin
                    state_d = ST_CAL;
                    cnt_d   = '0;
                end else if (start_wr || cont_d) begin
                    state_d = ST_CONV;
                    cnt_d   = '0;
                end
            end
            ST_CAL: begin
                if (valid_edge) begin
                    cal_done_set = 1'b1;
                    state_d      = ST_IDLE;
                end else if (tout_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CONV: begin
                if (valid_edge)    state_d = ST_GAP;
                else if (tout_hit) state_d = ST_IDLE;
                else               cnt_d   = cnt_q + CW'(1);
            end
            default: begin
                if (cont_d) begin
                    state_d = ST_CONV;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        ovf_d      = (ovf_q & ~(status_wr & wbs_dat_i[STS_OVF]))
                     | (fifo_push & fifo_full & ~fifo_pop);
        tout_d     = (tout_q & ~(status_wr & wbs_dat_i[STS_TOUT])) | tout_hit;
        cal_done_d = (cal_done_q & ~(status_wr & wbs_dat_i[STS_CAL_DONE])) | cal_done_set;
        adc_en_d   = (state_d == ST_CAL) || (state_d == ST_CONV);
        adc_cal_d  = (state_d == ST_CAL);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            valid_q    <= 1'b1;
            adc_en_q   <= 1'b0;
            adc_cal_q  <= 1'b0;
            cont_q     <= 1'b0;
            ie_data_q  <= 1'b0;
            ie_err_q   <= 1'b0;
            ovf_q      <= 1'b0;
            tout_q     <= 1'b0;
            cal_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            adc_en_q   <= adc_en_d;
            adc_cal_q  <= adc_cal_d;
            cont_q     <= cont_d;
            ie_data_q  <= ie_data_d;
            ie_err_q   <= ie_err_d;
            ovf_q      <= ovf_d;
            tout_q     <= tout_d;
            cal_done_q <= cal_done_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdata[CTRL_CONT]    = cont_q;
                rdata[CTRL_IE_DATA] = ie_data_q;
                rdata[CTRL_IE_ERR]  = ie_err_q;
            end
            REG_STATUS: begin
                rdata[STS_BUSY]             = (state_q != ST_IDLE);
                rdata[STS_COUNT_LSB +: 3]   = 3'(fifo_count);
                rdata[STS_OVF]              = ovf_q;
                rdata[STS_TOUT]             = tout_q;
                rdata[STS_CAL_DONE]         = cal_done_q;
            end
            REG_DATA: rdata = fifo_empty ? DATA_EMPTY : 32'(fifo_dout);
            default:  rdata = '0;
        endcase
    end

    assign wbs_dat_o = ack_q ? rdata : 32'h0;
    assign wbs_ack_o = ack_q;
    assign adc_en    = adc_en_q;
    assign adc_cal   = adc_cal_q;
    assign irq       = (ie_data_q & ~fifo_empty) | (ie_err_q & (ovf_q | tout_q));

    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:1],
                           wbs_dat_i[31:7], wbs_dat_i[3]};

endmodule

// File: tb/tb_saradc_seq.sv
// Self-checking bench for saradc_seq: Wishbone register access against a behavioural ADC
// model, with a queue scoreboard of expected FIFO contents.
module tb_saradc_seq;
    localparam logic [1:0] R_CTRL = 2'd0, R_STATUS = 2'd1, R_DATA = 2'd2, R_RSVD = 2'd3;

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i, dat_o;
    logic        ack;
    logic        adc_en, adc_cal, adc_valid;
    logic [9:0]  adc_result;
    logic        irq;

    int          total = 0;
    int          passed = 0;
    logic [9:0]  exp_q[$];
    bit          exp_ovf = 1'b0, exp_tout = 1'b0, exp_cal_done = 1'b0;

    saradc_seq #(.RES_W(10), .FIFO_DEPTH(4), .TIMEOUT(1023)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_dat_o  (dat_o),
        .wbs_ack_o  (ack),
        .adc_en     (adc_en),
        .adc_cal    (adc_cal),
        .adc_valid  (adc_valid),
        .adc_result (adc_result),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        return (32'(exp_q.size()) << 1) | (32'(exp_ovf) << 4) | (32'(exp_tout) << 5)
               | (32'(exp_cal_done) << 6);
    endfunction

    task automatic wb_cycle(input logic w, input logic [1:0] r, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] q);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = {28'h0, r, 2'b00}; dat_i = d;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (ack !== 1'b1 && n < 8);
        total++;
        if (ack === 1'b1) passed++;
        else $display("FAIL wb_ack: ack=%b, required 1 within 8 cycles", ack);
        q = dat_o;
        @(posedge clk); #1;
        total++;
        if (ack === 1'b0) passed++;
        else $display("FAIL wb_ack_single: ack=%b with strobe held, required 0", ack);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic adc_sample(input logic [9:0] v, input int dly);
        int n;
        n = 0;
        while (adc_en !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
        total++;
        if (adc_en === 1'b1) passed++;
        else $display("FAIL adc_en_wait: adc_en=%b, required 1 within 64 cycles", adc_en);
        repeat (dly) begin @(posedge clk); #1; end
        adc_result = v;
        adc_valid  = 1'b1;
        if (exp_q.size() < 4) exp_q.push_back(v);
        else exp_ovf = 1'b1;
        @(posedge clk); #1;
        total++;
        if (adc_en === 1'b0) passed++;
        else $display("FAIL adc_en_fall: adc_en=%b one cycle after valid edge, required 0", adc_en);
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] q;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
        adc_valid = 1'b1; adc_result = 10'h155;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if ({adc_en, adc_cal, irq, ack, dat_o} === 36'h0) passed++;
        else $display("FAIL reset_outputs: en=%b cal=%b irq=%b ack=%b dat=%h, required all 0",
                      adc_en, adc_cal, irq, ack, dat_o);
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        wb_cycle(1'b0, R_STATUS, 32'h0, 4'hF, q);
        total++;
        if (q === exp_status()) passed++;
        else $display("FAIL reset_status: got %h, required %h", q, exp_status());
        wb_cycle(1'b0, R_DATA, 32'h0, 4'hF, q);
        total++;
        if (q === 32'h8000_0000) passed++;
        else $display("FAIL reset_data_empty: got %h, required 80000000", q);
        wb_cycle(1'b0, R_RSVD, 32'h0, 4'hF, q);
        total++;
        if (q === 32'h0) passed++;
        else $display("FAIL reserved_read: got %h, required 0", q);
        adc_valid = 1'b0;
        wb_cycle(1'b1, R_CTRL, 32'h12, 4'hE, q);
        wb_cycle(1'b0, R_CTRL, 32'h0, 4'hF, q);
        total++;
        if (q === 32'h0 && adc_en === 1'b0) passed++;
        else $display("FAIL sel0_gate: ctrl=%h en=%b, required ctrl 0 en 0", q, adc_en);
    endtask

    task automatic test_single();
        logic [31:0] q, e;
        wb_cycle(1'b1, R_CTRL, 32'h01, 4'hF, q);
        total++;
        if (adc_en === 1'b1 && adc_cal === 1'b0) passed++;
        else $display("FAIL start_en: en=%b cal=%b, required en 1 cal 0", adc_en, adc_cal);
        adc_sample(10'h2A5, 20);
        wb_cycle(1'b0, R_STATUS, 32'h0, 4'hF, q);
        total++;
        if (q === exp_status()) passed++;
        else $display("FAIL single_status: got %h, required %h", q, exp_status());
        wb_cycle(1'b0, R_DATA, 32'h0, 4'hF, q);
        e = (exp_q.size() == 0) ? 32'h8000_0000 : {22'h0, exp_q.pop_front()};
        total++;
        if (q === e) passed++;
        else $display("FAIL single_data: got %h, required %h", q, e);
        wb_cycle(1'b0, R_STATUS, 32'h0, 4'hF, q);
        total++;
        if (q === exp_status() && irq === 1'b0) passed++;
        else $display("FAIL single_status_after: got %h irq=%b, required %h irq 0",
                      q, irq, exp_status());
    endtask

    task automatic test_cont_ovf();
        logic [31:0] q, e;
        wb_cycle(1'b1, R_CTRL, 32'h12, 4'hF, q);
        for (int i = 1; i <= 5; i++) adc_sample(10'(i), 3);
        wb_cycle(1'b1, R_CTRL, 32'h10, 4'hF, q);
        adc_sample(10'd6, 2);
        repeat (4) begin @(posedge clk); #1; end
        total++;
        if (adc_en === 1'b0) passed++;
        else $display("FAIL cont_stop: adc_en=%b after CONT cleared, required 0", adc_en);
        wb_cycle(1'b0, R_STATUS, 32'h0, 4'hF, q);
        total++;
        if (q === exp_status() && irq === 1'b1) passed++;
        else $display("FAIL ovf_status: got %h irq=%b, required %h irq 1", q, irq, exp_status());
        for (int i = 0; i < 5; i++) begin
            wb_cycle(1'b0, R_DATA, 32'h0, 4'hF, q);
            e = (exp_q.size() == 0) ? 32'h8000_0000 : {22'h0, exp_q.pop_front()};
            total++;
            if (q === e) passed++;
            else $display("FAIL cont_data[%0d]: got %h, required %h", i, q, e);
        end
        wb_cycle(1'b1, R_STATUS, 32'h10, 4'hF, q);
        exp_ovf = 1'b0;
        wb_cycle(1'b0, R_STATUS, 32'h0, 4'hF, q);
        total++;
        if (q === exp_status() && irq === 1'b0) passed++;
        else $display("FAIL ovf_w1c: got %h irq=%b, required %h irq 0", q, irq, exp_status());
    endtask

    task automatic test_cal();
        logic [31:0] q;
        wb_cycle(1'b1, R_CTRL, 32'h04, 4'hF, q);
        total++;
        if (adc_cal === 1'b1 && adc_en === 1'b1) passed++;
        else $display("FAIL cal_start: cal=%b en=%b, required 1 1", adc_cal, adc_en);
        repeat (10) begin @(posedge clk); #1; end
        total++;
        if (adc_cal === 1'b1 && adc_en === 1'b1) passed++;
        else $display("FAIL cal_hold: cal=%b en=%b, required 1 1", adc_cal, adc_en);
        adc_result = 10'h3FF;
        adc_valid  = 1'b1;
        @(posedge clk); #1;
        total++;
        if (adc_cal === 1'b0 && adc_en === 1'b0) passed++;
        else $display("FAIL cal_end: cal=%b en=%b, required 0 0", adc_cal, adc_en);
        adc_valid = 1'b0;
        exp_cal_done = 1'b1;
        wb_cycle(1'b0, R_STATUS, 32'h0, 4'hF, q);
        total++;
        if (q === exp_status()) passed++;
        else $display("FAIL cal_done: got %h, required %h", q, exp_status());
        wb_cycle(1'b1, R_STATUS, 32'h40, 4'hF, q);
        exp_cal_done = 1'b0;
        wb_cycle(1'b0, R_STATUS, 32'h0, 4'hF, q);
        total++;
        if (q === exp_status()) passed++;
        else $display("FAIL cal_w1c: got %h, required %h", q, exp_status());
    endtask

    task automatic test_timeout();
        logic [31:0] q;
        int n;
        wb_cycle(1'b1, R_CTRL, 32'h22, 4'hF, q);
        n = 0;
        while (adc_en === 1'b1 && n < 1100) begin @(posedge clk); #1; n++; end
        total++;
        if (n >= 1023 && n <= 1024 && adc_en === 1'b0) passed++;
        else $display("FAIL timeout_len: adc_en high %0d cycles, required 1023..1024", n);
        exp_tout = 1'b1;
        wb_cycle(1'b0, R_STATUS, 32'h0, 4'hF, q);
        total++;
        if (q === exp_status() && irq === 1'b1) passed++;
        else $display("FAIL tout_status: got %h irq=%b, required %h irq 1", q, irq, exp_status());
        wb_cycle(1'b0, R_CTRL, 32'h0, 4'hF, q);
        total++;
        if (q === 32'h20 && adc_en === 1'b0) passed++;
        else $display("FAIL tout_cont_clr: ctrl=%h en=%b, required 00000020 en 0", q, adc_en);
        wb_cycle(1'b1, R_STATUS, 32'h20, 4'hF, q);
        exp_tout = 1'b0;
        total++;
        if (irq === 1'b0) passed++;
        else $display("FAIL tout_w1c_irq: irq=%b, required 0", irq);
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, qa, e;
        wb_cycle(1'b1, R_CTRL, 32'h02, 4'hF, q);
        for (int i = 1; i <= 4; i++) adc_sample(10'h100 + 10'(i), 2);
        wb_cycle(1'b1, R_CTRL, 32'h00, 4'hF, q);
        e = {22'h0, exp_q[0]};
        fork
            wb_cycle(1'b0, R_DATA, 32'h0, 4'hF, qa);
            begin
                @(posedge clk); #1;
                adc_result = 10'h155;
                adc_valid  = 1'b1;
                exp_q.push_back(10'h155);
                @(posedge clk); #1;
                adc_valid = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        total++;
        if (qa === e) passed++;
        else $display("FAIL pop_push_head: got %h, required %h", qa, e);
        wb_cycle(1'b0, R_STATUS, 32'h0, 4'hF, q);
        total++;
        if (q === exp_status()) passed++;
        else $display("FAIL pop_push_status: got %h, required %h", q, exp_status());
        for (int i = 0; i < 4; i++) begin
            wb_cycle(1'b0, R_DATA, 32'h0, 4'hF, q);
            e = (exp_q.size() == 0) ? 32'h8000_0000 : {22'h0, exp_q.pop_front()};
            total++;
            if (q === e) passed++;
            else $display("FAIL pop_push_order[%0d]: got %h, required %h", i, q, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        wb_cycle(1'b1, R_CTRL, 32'h01, 4'hF, q);
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (adc_en === 1'b0 && adc_cal === 1'b0) passed++;
        else $display("FAIL reset_mid: en=%b cal=%b, required 0 0", adc_en, adc_cal);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_cont_ovf();
        test_cal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/saradc_seq.md
# saradc_seq

Digital sequencer and result reader for the on-chip 10-bit SAR ADC. Drives the ADC's `en`/`cal` inputs, captures `result` on the rising edge of `valid`, buffers samples in a small FIFO and exposes control, status and data to the management core over the Wishbone slave port of the user project wrapper. Single-shot, continuous and calibration sequences; interrupt on data available or error.

## Interface
- `RES_W`, 10: ADC result width.
- `FIFO_DEPTH`, 4: sample buffer depth (power of two, ≥2).
- `TIMEOUT`, 1023: max cycles from `adc_en` rise to `valid` before error.
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone classic cycle/strobe/write.
- `wbs_sel_i` in 4: byte selects; only byte 0 qualifies writes.
- `wbs_adr_i` in 32: address; `[3:2]` selects register, others ignored.
- `wbs_dat_i` in 32: write data.
- `wbs_dat_o` out 32: read data.
- `wbs_ack_o` out 1: transfer acknowledge.
- `adc_en` out 1: conversion enable to ADC.
- `adc_cal` out 1: calibration request to ADC.
- `adc_valid` in 1: ADC result valid (level; rising edge is the event).
- `adc_result` in RES_W: ADC conversion result.
- `irq` out 1: level interrupt to `user_irq[0]`.

## Operation
- Registers (`adr[3:2]`): 0 CTRL rw: bit0 START (self-clearing), bit1 CONT, bit2 CAL (self-clearing), bit4 IE_DATA, bit5 IE_ERR. 1 STATUS: bit0 BUSY, bits[3:1] COUNT, bit4 OVF (sticky, W1C), bit5 TOUT (sticky, W1C), bit6 CAL_DONE (sticky, W1C). 2 DATA ro: `{EMPTY, 21'b0, result}`; read pops one entry if non-empty; read when empty returns 0x8000_0000, no pop. 3 reserved, reads 0, writes ignored.
- FSM states: IDLE, CAL, CONV, GAP.
  - IDLE: CAL bit set → CAL; else START or CONT set → CONV. CAL wins if both written together.
  - CAL: `adc_cal=1`, `adc_en=1`; on valid edge → set CAL_DONE, discard result, → IDLE.
  - CONV: `adc_en=1`; on valid edge → push `adc_result`, → GAP.
  - GAP: one cycle `adc_en=0`; CONT=1 → CONV, else → IDLE.
  - In CAL/CONV, timeout counter reaching TIMEOUT → set TOUT, drop `adc_en`/`adc_cal`, → IDLE, clear CONT.
- Valid edge = `adc_valid & ~valid_q`; `valid_q` resets to 1 so a stuck-high valid at reset is not an event.
- FIFO full on push: sample dropped, OVF set; FSM proceeds normally. Push and pop same cycle: both apply, COUNT unchanged. Pop while full with push: neither lost.
- Clearing CONT mid-conversion completes the current sample, then IDLE.
- `irq = (IE_DATA & COUNT≠0) | (IE_ERR & (OVF|TOUT))`.

## Timing
- Reset: all outputs 0, FSM IDLE, FIFO empty, all CTRL/STATUS bits 0, counter 0. Reset mid-conversion drops `adc_en`/`adc_cal` in the next cycle.
- Wishbone: `wbs_ack_o` asserted exactly one cycle, the cycle after `cyc&stb` is sampled with ack low; deasserted the following cycle even if strobe held (no back-to-back acks). Write side effects and pops take effect on the ack cycle; `wbs_dat_o` valid on ack, 0 otherwise.
- START write on ack cycle N → `adc_en` high at N+1 (transition to CONV in N+1).
- Valid edge seen at cycle M (valid_q registered) → sample in FIFO and COUNT updated at M+1; `adc_en` low at M+1.
- Timeout counter clears on entry to CAL/CONV; TOUT set when it equals TIMEOUT.

## Structure
- Package `saradc_pkg`: state enum, register offsets, CTRL/STATUS bit indices, EMPTY data constant.
- Sub-module `saradc_fifo`: synchronous FIFO (push, pop, full, empty, count) parameterised by width and depth.
- Top `saradc_seq`: Wishbone decode, register file, FSM, edge detect, timeout counter.

## Test plan
- Reset with `adc_valid=1` held → no push, all outputs 0, DATA read returns 0x8000_0000.
- Write CTRL=0x01; ADC model raises valid with result 0x2A5 after 20 cycles → `adc_en` falls, COUNT=1, DATA read 0x0000_02A5, COUNT=0, BUSY=0.
- CONT=1, IE_DATA=1, no reads, 6 samples 1..6 → FIFO holds 1..4, OVF=1, `irq`=1; reads return 1,2,3,4 then 0x8000_0000.
- Write CTRL=0x04 → `adc_cal` and `adc_en` high until valid edge, FIFO unchanged, CAL_DONE=1; W1C clears it.
- START with ADC never asserting valid → `adc_en` drops after 1023 cycles, TOUT=1, `irq` with IE_ERR=1.
- Pop on same cycle as valid-edge push with COUNT=4 → COUNT stays 4, OVF stays 0, order preserved.
